decoder_scan: RTL and testbench

// - Parametrised SEL_W-to-2^SEL_W one-hot decoder with registered outputs and two modes.
// - DIRECT: a loaded index is decoded and held.
// - SCAN: the one-hot output rotates through all lines at a programmable dwell rate.
// - Drives channel or digit selects (multi-channel UART select, display digit strobes) from one clock domain.

---
 rtl/decoder_scan_pkg.sv | 8 +
 rtl/decoder_scan_onehot_dec.sv | 10 +
 rtl/decoder_scan.sv | 72 +++++++
 tb/tb_decoder_scan.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: FSM state encodings and mode constants shared by the decoder_scan slice.
package decoder_scan_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// decoder_scan_onehot_dec: combinational index to one-hot line decoder.
module decoder_scan_onehot_dec #(
  parameter int SEL_W = 2,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] idx,
  output logic [OUT_W-1:0] y
);
  assign y = OUT_W'(1) << idx;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot select with DIRECT (hold loaded index) and SCAN (rotating dwell) modes.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DIV_W = 16,
  localparam int OUT_W = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [DIV_W-1:0] div,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap,
  output logic             busy
);
  logic [1:0] st, st_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic wrap_nxt;
  logic [OUT_W-1:0] dec;
  logic change, term;
  assign change = st == ST_IDLE || (st == ST_DIRECT && mode != MODE_DIRECT) || (st == ST_SCAN && mode == MODE_DIRECT);
  assign term = cnt >= div;
  assign busy = st != ST_IDLE;
  // A state change swallows any load presented in the same cycle; load beats a terminal step.
  always_comb begin
    st_nxt = st;
    idx_nxt = idx;
    cnt_nxt = cnt;
    wrap_nxt = 1'b0;
    if (!en) begin
      st_nxt = ST_IDLE;
      idx_nxt = '0;
      cnt_nxt = '0;
    end else if (change) begin
      st_nxt = mode == MODE_SCAN ? ST_SCAN : ST_DIRECT;
      idx_nxt = mode == MODE_SCAN ? '0 : idx;
      cnt_nxt = '0;
    end else if (load) begin
      idx_nxt = sel_in;
      cnt_nxt = '0;
    end else if (st == ST_SCAN) begin
      cnt_nxt = term ? '0 : cnt + 1'b1;
      idx_nxt = term ? idx + 1'b1 : idx;
      wrap_nxt = term && (&idx);
    end
  end
  decoder_scan_onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx(idx_nxt),
    .y  (dec)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
      idx <= '0;
      cnt <= '0;
      wrap <= 1'b0;
      y <= '0;
    end else begin
      st <= st_nxt;
      idx <= idx_nxt;
      cnt <= cnt_nxt;
      wrap <= wrap_nxt;
      y <= st_nxt == ST_IDLE ? '0 : dec;
    end
  end
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: randomized and directed checks of decoder_scan (SEL_W=2 and SEL_W=3) against a behavioural model.
module tb_decoder_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic load = 1'b0;
  logic [2:0] sel3 = '0;
  logic [15:0] div = '0;
  logic [3:0] y2;
  logic [1:0] idx2;
  logic wrap2, busy2;
  logic [7:0] y3;
  logic [2:0] idx3;
  logic wrap3, busy3;
  int n_chk = 0;
  int n_pass = 0;
  int m_st[2] = '{0, 0};
  int m_idx[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  bit m_wrap[2] = '{0, 0};
  int ow[2] = '{4, 8};

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(2), .DIV_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel_in(sel3[1:0]), .div(div), .y(y2), .idx(idx2), .wrap(wrap2), .busy(busy2)
  );
  decoder_scan #(.SEL_W(3), .DIV_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load),
    .sel_in(sel3), .div(div), .y(y3), .idx(idx3), .wrap(wrap3), .busy(busy3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // model states: 0 idle, 1 direct, 2 scan
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] <= 0;
        m_idx[i] <= 0;
        m_cnt[i] <= 0;
        m_wrap[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int s = m_st[i];
        automatic int ix = m_idx[i];
        automatic int c = m_cnt[i];
        automatic bit w = 0;
        automatic int sel = int'(sel3) % ow[i];
        if (!en) begin
          s = 0; ix = 0; c = 0;
        end else if (s == 0 || (s == 1 && mode) || (s == 2 && !mode)) begin
          if (mode) begin s = 2; ix = 0; c = 0; end
          else s = 1;
        end else if (load) begin
          ix = sel; c = 0;
        end else if (s == 2) begin
          if (c >= int'(div)) begin
            c = 0;
            w = (ix == ow[i] - 1);
            ix = (ix + 1) % ow[i];
          end else c++;
        end
        m_st[i] <= s;
        m_idx[i] <= ix;
        m_cnt[i] <= c;
        m_wrap[i] <= w;
      end
    end
  end

  always @(negedge clk) begin
    chk("y2", int'(y2), m_st[0] != 0 ? 1 << m_idx[0] : 0);
    chk("idx2", int'(idx2), m_idx[0]);
    chk("wrap2", int'(wrap2), int'(m_wrap[0]));
    chk("busy2", int'(busy2), int'(m_st[0] != 0));
    chk("onehot2", int'($countones(y2) <= 1), 1);
    chk("y3", int'(y3), m_st[1] != 0 ? 1 << m_idx[1] : 0);
    chk("idx3", int'(idx3), m_idx[1]);
    chk("wrap3", int'(wrap3), int'(m_wrap[1]));
    chk("busy3", int'(busy3), int'(m_st[1] != 0));
    chk("onehot3", int'($countones(y3) <= 1), 1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int wraps;
    cyc(2);
    chk("rst_y", int'(y2), 0);
    chk("rst_idx", int'(idx2), 0);
    chk("rst_wrap", int'(wrap2), 0);
    chk("rst_busy", int'(busy2), 0);
    rst_n = 1'b1;
    cyc(2);
    chk("blank_y", int'(y2), 0);
    chk("blank_busy", int'(busy2), 0);
    en = 1'b1; mode = 1'b0;
    cyc(1);
    chk("dir_entry", int'(y2), 4'b0001);
    sel3 = 3'd2; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("dir_load2", int'(y2), 4'b0100);
    for (int k = 0; k < 10; k++) begin
      cyc(1);
      chk("dir_hold", int'(y2), 4'b0100);
    end
    sel3 = 3'd3; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("dir_load3", int'(y2), 4'b1000);
    div = 16'd2; mode = 1'b1;
    cyc(1);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) cyc(1);
      chk("scan_div2_y", int'(y2), 1 << ((k / 3) % 4));
      chk("scan_div2_wrap", int'(wrap2), int'(k == 12));
    end
    sel3 = 3'd3; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("scan_load3", int'(idx2), 3);
    cyc(2);
    sel3 = 3'd1; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("term_load_idx", int'(idx2), 1);
    chk("term_load_wrap", int'(wrap2), 0);
    chk("term_load_y", int'(y2), 4'b0010);
    cyc(1);
    chk("term_load_hold", int'(idx2), 1);
    sel3 = 3'd2; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("scan_load2", int'(idx2), 2);
    mode = 1'b0;
    cyc(1);
    chk("to_direct_y", int'(y2), 4'b0100);
    cyc(3);
    chk("to_direct_hold", int'(y2), 4'b0100);
    en = 1'b0;
    cyc(1);
    chk("disable_y", int'(y2), 0);
    chk("disable_busy", int'(busy2), 0);
    en = 1'b1; mode = 1'b1; div = 16'd5;
    cyc(4);
    chk("div5_cnt3_idx", int'(idx2), 0);
    div = 16'd1;
    cyc(1);
    chk("div_lowered_idx", int'(idx2), 1);
    en = 1'b0;
    cyc(1);
    en = 1'b1; mode = 1'b1; div = 16'd0;
    cyc(1);
    wraps = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) cyc(1);
      chk("rot4_y", int'(y2), 1 << (k % 4));
      chk("rot4_wrap", int'(wrap2), int'(k > 0 && k % 4 == 0));
      chk("rot8_y", int'(y3), 1 << (k % 8));
      chk("rot8_wrap", int'(wrap3), int'(k > 0 && k % 8 == 0));
      wraps += int'(wrap2);
    end
    chk("rot4_wrap_count", wraps, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", int'(y2), 0);
    chk("async_rst_idx", int'(idx2), 0);
    chk("async_rst_wrap", int'(wrap2), 0);
    chk("async_rst_busy", int'(busy2), 0);
    chk("async_rst_y3", int'(y3), 0);
    cyc(1);
    en = 1'b0; rst_n = 1'b1;
    cyc(3);
    chk("post_rst_blank", int'(y2), 0);
    en = 1'b1;
    cyc(1);
    chk("post_rst_resume", int'(y2), 4'b0001);
    for (int k = 0; k < 800; k++) begin
      en = $urandom_range(0, 19) != 0;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      load = $urandom_range(0, 4) == 0;
      sel3 = 3'($urandom);
      if ($urandom_range(0, 15) == 0) div = 16'($urandom_range(0, 4));
      cyc(1);
    end
    load = 1'b0;
    cyc(1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
